channel_broadcast: RTL and testbench
====================================

CHANNEL_BROADCAST -- requirements
Module: channel_broadcast

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width, Q8.8 signed.
REQ-002 Parameter CHANNELS, default 16, number of per-channel values per frame.
REQ-003 Parameter FRAME_LEN, default 4, spatial length; power of 2, >= 2.
REQ-004 Parameter AVG_MODE, default 0; 1 = divide each broadcast value by FRAME_LEN.
REQ-005 Port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-006 Port rst_n, input, 1 bit, reset is synchronous and active-low.
REQ-007 Port start, input, 1 bit, begins a frame when idle.
REQ-008 Port data_in, input, DATA_WIDTH bits signed, one value per channel, order ch0, ch1, ... ch(CHANNELS-1).
REQ-009 Port valid_in, input, 1 bit, data_in valid.
REQ-010 Port ready_in, output, 1 bit, block accepts data_in.
REQ-011 Port data_out, output, DATA_WIDTH bits signed, order ch0[0..FRAME_LEN-1], ch1[0..FRAME_LEN-1], ...
REQ-012 Port valid_out, output, 1 bit, data_out valid.
REQ-013 Port ready_out, input, 1 bit, downstream accepts data_out.
REQ-014 Port busy, output, 1 bit, high in LOAD and EMIT.
REQ-015 Port done, output, 1 bit, one-cycle pulse at frame completion.

Function
REQ-016 FSM states IDLE, LOAD, EMIT, DONE; the SHALL state register is the only source of ready_in/valid_out/busy/done.
REQ-017 IDLE -> LOAD on start=1; start in any other state SHALL be ignored.
REQ-018 LOAD: ready_in=1; each valid_in=1 cycle SHALL write data_in to buffer[ch_cnt] and increment ch_cnt.
REQ-019 LOAD -> EMIT on the accepted beat with ch_cnt=CHANNELS-1; ch_cnt then SHALL clear to 0.
REQ-020 valid_in while not in LOAD SHALL be ignored (ready_in=0); no buffer write.
REQ-021 EMIT: valid_out=1, data_out = buffer[ch_cnt] (AVG_MODE=0) or buffer[ch_cnt] >>> log2(FRAME_LEN), arithmetic (AVG_MODE=1).
REQ-022 EMIT beat transfers when valid_out and ready_out both 1; pos_cnt advances 0..FRAME_LEN-1, then clears with ch_cnt increment.
REQ-023 ready_out=0 in EMIT SHALL hold data_out, valid_out and counters unchanged.
REQ-024 EMIT -> DONE on transfer with ch_cnt=CHANNELS-1 and pos_cnt=FRAME_LEN-1; counters clear to 0.
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then -> IDLE unconditionally.
REQ-026 Latency: first valid_out in the cycle after the last input beat is accepted; frame emits exactly CHANNELS*FRAME_LEN beats.
REQ-027 Outside EMIT, data_out SHALL be 0 and valid_out 0.
REQ-028 No saturation needed: shift never overflows; output width equals input width.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set state IDLE, ch_cnt=0, pos_cnt=0, all buffer entries 0.
REQ-030 Post-reset outputs: ready_in=0, valid_out=0, data_out=0, busy=0, done=0.
REQ-031 Reset during LOAD or EMIT SHALL abort the frame with no done pulse; next frame needs a fresh start.
REQ-032 Inputs during reset SHALL be ignored, including start.

Verification
REQ-033 CHANNELS=4, FRAME_LEN=4, AVG_MODE=0, ready_out=1; inputs 0x0100,0x0200,0x0300,0x0400 -> 16 beats: 0x0100 x4, 0x0200 x4, 0x0300 x4, 0x0400 x4; done pulses 1 cycle after last beat.
REQ-034 AVG_MODE=1, same sizes; inputs 0x0100,0xFF00,0x7FFF,0x8000 -> 0x0040 x4, 0xFFC0 x4, 0x1FFF x4, 0xE000 x4.
REQ-035 Backpressure: ready_out toggled 1,0,0,1 repeating -> data_out stable while ready_out=0; exact 16-beat sequence preserved; no drop or duplicate.
REQ-036 Input gaps: valid_in low 3 cycles between beats -> buffer contents correct; ready_in stays 1 through gaps; valid_in asserted in IDLE not captured.
REQ-037 rst_n=0 for one cycle mid-EMIT (beat 6) -> next cycle IDLE, valid_out=0, no done; new start + 4 inputs gives clean full frame.
REQ-038 start asserted during LOAD and EMIT -> no effect; frame completes normally with single done pulse.

Source files
------------

// File: rtl/channel_broadcast_if.sv
// Streaming ports of channel_broadcast: an input channel stream and an output broadcast stream.
interface channel_broadcast_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         valid_in;
  logic                         ready_in;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         valid_out;
  logic                         ready_out;

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out
  );
endinterface

// File: rtl/channel_broadcast.sv
// Captures one value per channel, then replays each value FRAME_LEN times (optionally
// averaged by an arithmetic right shift) on a ready/valid output stream.
module channel_broadcast #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 16,
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned AVG_MODE   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  channel_broadcast_if.slave bus,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ChW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PosW  = $clog2(FRAME_LEN);
  localparam int unsigned Shift = $clog2(FRAME_LEN);
  localparam logic [ChW-1:0]  ChLast  = ChW'(CHANNELS - 1);
  localparam logic [PosW-1:0] PosLast = PosW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

  state_e                       state_q, state_d;
  logic [ChW-1:0]               ch_cnt_q, ch_cnt_d;
  logic [PosW-1:0]              pos_cnt_q, pos_cnt_d;
  logic signed [DATA_WIDTH-1:0] buffer_q [CHANNELS];
  logic                         wr_en;
  logic signed [DATA_WIDTH-1:0] sel_val;
  logic signed [DATA_WIDTH-1:0] emit_val;

  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pos_cnt_d = pos_cnt_q;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (bus.valid_in) begin
          wr_en = 1'b1;
          if (ch_cnt_q == ChLast) begin
            ch_cnt_d = '0;
            state_d  = StEmit;
          end else begin
            ch_cnt_d = ch_cnt_q + ChW'(1);
          end
        end
      end
      StEmit: begin
        if (bus.ready_out) begin
          if (pos_cnt_q == PosLast) begin
            pos_cnt_d = '0;
            if (ch_cnt_q == ChLast) begin
              ch_cnt_d = '0;
              state_d  = StDone;
            end else begin
              ch_cnt_d = ch_cnt_q + ChW'(1);
            end
          end else begin
            pos_cnt_d = pos_cnt_q + PosW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_cnt_q  <= '0;
      pos_cnt_q <= '0;
      buffer_q  <= '{default: '0};
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pos_cnt_q <= pos_cnt_d;
      if (wr_en) buffer_q[ch_cnt_q] <= bus.data_in;
    end
  end

  // Shift by log2(FRAME_LEN) is a divide that cannot overflow the input width.
  assign sel_val  = buffer_q[ch_cnt_q];
  assign emit_val = (AVG_MODE != 0) ? (sel_val >>> Shift) : sel_val;

  assign bus.ready_in  = (state_q == StLoad);
  assign bus.valid_out = (state_q == StEmit);
  assign bus.data_out  = (state_q == StEmit) ? emit_val : '0;
  assign busy          = (state_q == StLoad) || (state_q == StEmit);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_channel_broadcast.sv
// Drives two instances (plain and averaging) with identical stimulus and checks both
// against hand-computed frames.
module tb_channel_broadcast;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [15:0] data_in;
  logic               valid_in;
  logic               ready_out;
  logic               busy0, done0, busy1, done1;

  channel_broadcast_if #(.DATA_WIDTH(16)) if0 ();
  channel_broadcast_if #(.DATA_WIDTH(16)) if1 ();

  assign if0.data_in   = data_in;
  assign if0.valid_in  = valid_in;
  assign if0.ready_out = ready_out;
  assign if1.data_in   = data_in;
  assign if1.valid_in  = valid_in;
  assign if1.ready_out = ready_out;

  channel_broadcast #(
    .DATA_WIDTH(16), .CHANNELS(4), .FRAME_LEN(4), .AVG_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if0), .busy(busy0), .done(done0)
  );

  channel_broadcast #(
    .DATA_WIDTH(16), .CHANNELS(4), .FRAME_LEN(4), .AVG_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(if1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // Channel arrays are packed {ch3, ch2, ch1, ch0}.
  typedef struct packed {
    logic [3:0][15:0] din;
    logic [3:0][15:0] exp1;
    logic             bp;
    logic [1:0]       gap;
    logic             poke;
  } vec_t;

  vec_t tbl [5];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready_in0"}, 16'(if0.ready_in), 16'd0);
    check({tag, " valid_out0"}, 16'(if0.valid_out), 16'd0);
    check({tag, " data_out0"}, if0.data_out, 16'd0);
    check({tag, " busy0"}, 16'(busy0), 16'd0);
    check({tag, " done0"}, 16'(done0), 16'd0);
    check({tag, " valid_out1"}, 16'(if1.valid_out), 16'd0);
    check({tag, " busy1"}, 16'(busy1), 16'd0);
    check({tag, " done1"}, 16'(done1), 16'd0);
  endtask

  // Entered at a negedge in IDLE; returns at the negedge of the first EMIT cycle.
  task automatic load_frame(input int i);
    check_idle("pre-start");
    start    = 1'b1;
    valid_in = 1'b1;
    data_in  = 16'h7777;  // offered while idle: must not be captured
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int g = 0; g < int'(tbl[i].gap); g++) begin
        valid_in = 1'b0;
        check("gap ready_in", 16'(if0.ready_in), 16'd1);
        @(negedge clk);
      end
      check("load ready_in", 16'(if0.ready_in), 16'd1);
      check("load busy", 16'(busy0), 16'd1);
      valid_in = 1'b1;
      data_in  = tbl[i].din[c];
      start    = tbl[i].poke && (c == 1);
      @(negedge clk);
    end
    valid_in = 1'b0;
    start    = 1'b0;
  endtask

  // Consumes stop_at beats; at 16 the done pulse and return to idle are checked as well.
  task automatic emit_frame(input int i, input int stop_at);
    int beats = 0;
    int cyc   = 0;
    logic ro;
    while (beats < stop_at && cyc < 64) begin
      check("valid_out0", 16'(if0.valid_out), 16'd1);
      check("valid_out1", 16'(if1.valid_out), 16'd1);
      check("data_out0", if0.data_out, tbl[i].din[beats / 4]);
      check("data_out1", if1.data_out, tbl[i].exp1[beats / 4]);
      ro        = tbl[i].bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      ready_out = ro;
      start     = tbl[i].poke && (cyc == 2);
      if (ro) beats++;
      cyc++;
      @(negedge clk);
    end
    ready_out = 1'b1;
    start     = 1'b0;
    check("beat count", 16'(beats), 16'(stop_at));
    if (stop_at == 16) begin
      check("done0 pulse", 16'(done0), 16'd1);
      check("done1 pulse", 16'(done1), 16'd1);
      check("done busy", 16'(busy0), 16'd0);
      check("done valid_out", 16'(if0.valid_out), 16'd0);
      check("done data_out", if0.data_out, 16'd0);
      @(negedge clk);
      check_idle("post-done");
    end
  endtask

  initial begin
    tbl[0] = '{din: {16'h0400, 16'h0300, 16'h0200, 16'h0100},
               exp1: {16'h0100, 16'h00C0, 16'h0080, 16'h0040}, bp: 1'b0, gap: 2'd0, poke: 1'b0};
    tbl[1] = '{din: {16'h8000, 16'h7FFF, 16'hFF00, 16'h0100},
               exp1: {16'hE000, 16'h1FFF, 16'hFFC0, 16'h0040}, bp: 1'b0, gap: 2'd0, poke: 1'b0};
    tbl[2] = '{din: {16'h0400, 16'h0300, 16'h0200, 16'h0100},
               exp1: {16'h0100, 16'h00C0, 16'h0080, 16'h0040}, bp: 1'b1, gap: 2'd3, poke: 1'b1};
    tbl[3] = '{din: {16'h8001, 16'h0003, 16'hFFFF, 16'h1234},
               exp1: {16'hE000, 16'h0000, 16'hFFFF, 16'h048D}, bp: 1'b1, gap: 2'd0, poke: 1'b0};
    tbl[4] = '{din: {16'h8000, 16'h7FFF, 16'hFF00, 16'h0100},
               exp1: {16'hE000, 16'h1FFF, 16'hFFC0, 16'h0040}, bp: 1'b0, gap: 2'd3, poke: 1'b1};

    rst_n     = 1'b0;
    start     = 1'b1;
    valid_in  = 1'b1;
    data_in   = 16'h5555;
    ready_out = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("in-reset");
    rst_n    = 1'b1;
    start    = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check_idle("post-reset");

    for (int i = 0; i < 5; i++) begin
      load_frame(i);
      emit_frame(i, 16);
    end

    // Reset after six beats of EMIT aborts the frame; start held during reset is ignored.
    load_frame(0);
    emit_frame(0, 6);
    rst_n    = 1'b0;
    start    = 1'b1;
    valid_in = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    start    = 1'b0;
    valid_in = 1'b0;
    check_idle("after abort");
    @(negedge clk);
    check_idle("abort settle");
    load_frame(1);
    emit_frame(1, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
